// File: rtl/cordic_wrapper_pkg.sv
// Shared types and constants for the CORDIC test wrapper output path.
// The serializer state enum is exported so checkers can bind to it directly.
package cordic_wrapper_pkg;

  typedef enum logic {
    SER_IDLE = 1'b0,
    SER_SEND = 1'b1
  } e_ser_state;

  localparam int SER_DATA_WIDTH = 56;
  localparam int SER_LANE_WIDTH = 8;
  localparam int SER_FIFO_DEPTH = 4;
  localparam int SER_BEATS      = SER_DATA_WIDTH / SER_LANE_WIDTH;
  localparam int DROP_CNT_W     = 8;

endpackage

// File: rtl/out_word_fifo.sv
// Word buffer between the CORDIC wrapper and the serializer FSM.
// A push on a full FIFO is still accepted when a pop happens in the same cycle.
module out_word_fifo #(
  parameter int WIDTH = 56,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_wr;
  logic             do_rd;

  assign do_rd = pop & ~empty;
  assign do_wr = push & (~full | do_rd);

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  // When full, wr_ptr == rd_ptr: the read below still sees the old word this cycle.
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cordic_out_serializer.sv
// Buffers wide CORDIC result words and streams them MS slice first over a narrow
// valid/ready lane; words arriving on a full buffer are dropped and counted.
module cordic_out_serializer
  import cordic_wrapper_pkg::*;
#(
  parameter int DATA_WIDTH = SER_DATA_WIDTH,
  parameter int LANE_WIDTH = SER_LANE_WIDTH,
  parameter int FIFO_DEPTH = SER_FIFO_DEPTH
) (
  input  logic                  i_clk,
  input  logic                  i_async_rst_n,
  input  logic                  i_en,
  input  logic                  i_vld,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_ready,
  output logic                  o_lane_vld,
  output logic [LANE_WIDTH-1:0] o_lane,
  output logic                  o_sof,
  output logic                  o_fifo_full,
  output logic                  o_overflow,
  output logic [DROP_CNT_W-1:0] o_drop_cnt,
  output e_ser_state            o_dbg_state
);

  // Lane handshake: a beat transfers on a rising edge where o_lane_vld, i_ready
  // and i_en are all high. o_lane/o_sof/o_lane_vld hold until that edge.

  localparam int BEATS  = DATA_WIDTH / LANE_WIDTH;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  e_ser_state            state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [BEAT_W-1:0]     beat_cnt;
  logic                  overflow;
  logic [DROP_CNT_W-1:0] drop_cnt;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic                  push_req;
  logic                  pop;
  logic                  beat_hs;
  logic                  last_beat;
  logic                  drop;

  assign push_req  = i_en & i_vld;
  assign last_beat = (beat_cnt == BEAT_W'(BEATS - 1));
  assign beat_hs   = i_en & (state == SER_SEND) & i_ready;
  assign pop       = i_en & ~fifo_empty &
                     ((state == SER_IDLE) | (beat_hs & last_beat));
  assign drop      = push_req & fifo_full & ~pop;

  out_word_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst_n (i_async_rst_n),
    .push  (push_req),
    .wdata (i_data),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge i_clk or negedge i_async_rst_n) begin
    if (!i_async_rst_n) begin
      state    <= SER_IDLE;
      shreg    <= '0;
      beat_cnt <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (i_en) begin
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      end
      case (state)
        SER_IDLE: begin
          if (!fifo_empty) begin
            shreg    <= fifo_rdata;
            beat_cnt <= '0;
            state    <= SER_SEND;
          end
        end
        SER_SEND: begin
          if (i_ready) begin
            if (last_beat) begin
              // Back-to-back words: reload without an idle bubble.
              if (!fifo_empty) begin
                shreg    <= fifo_rdata;
                beat_cnt <= '0;
              end else begin
                state <= SER_IDLE;
              end
            end else begin
              shreg    <= {shreg[DATA_WIDTH-LANE_WIDTH-1:0], {LANE_WIDTH{1'b0}}};
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        default: state <= SER_IDLE;
      endcase
    end
  end

  assign o_lane      = shreg[DATA_WIDTH-1 -: LANE_WIDTH];
  assign o_lane_vld  = (state == SER_SEND);
  assign o_sof       = (state == SER_SEND) && (beat_cnt == '0);
  assign o_fifo_full = fifo_full;
  assign o_overflow  = overflow;
  assign o_drop_cnt  = drop_cnt;
  assign o_dbg_state = state;

endmodule

// File: tb/tb_cordic_out_serializer.sv
// Scoreboard bench for cordic_out_serializer: a word-level model predicts beats,
// buffer occupancy and drops; a negedge monitor compares the lane against it.
module tb_cordic_out_serializer;
  import cordic_wrapper_pkg::*;

  localparam int DW    = 56;
  localparam int LW    = 8;
  localparam int DEPTH = 4;
  localparam int BEATS = DW / LW;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic          vld;
  logic [DW-1:0] data;
  logic          rdy;
  logic          lane_vld;
  logic [LW-1:0] lane;
  logic          sof;
  logic          fifo_full;
  logic          overflow;
  logic [7:0]    drop_cnt;
  e_ser_state    dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: expected beats as {sof, lane}, buffered words, beats left in flight.
  logic [LW:0]   exp_q[$];
  logic [DW-1:0] m_fifo[$];
  int            m_left;
  logic          m_ovf;
  int            m_drops;

  cordic_out_serializer #(
    .DATA_WIDTH (DW),
    .LANE_WIDTH (LW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .i_clk         (clk),
    .i_async_rst_n (rst_n),
    .i_en          (en),
    .i_vld         (vld),
    .i_data        (data),
    .i_ready       (rdy),
    .o_lane_vld    (lane_vld),
    .o_lane        (lane),
    .o_sof         (sof),
    .o_fifo_full   (fifo_full),
    .o_overflow    (overflow),
    .o_drop_cnt    (drop_cnt),
    .o_dbg_state   (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [LW-1:0] beat_of(input logic [DW-1:0] w, input int k);
    return w[DW-1-k*LW -: LW];
  endfunction

  // ---------------- reference model ----------------
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_fifo.delete();
      m_left  = 0;
      m_ovf   = 1'b0;
      m_drops = 0;
    end else if (en) begin
      bit hs, popped;
      hs     = (m_left > 0) && rdy;
      popped = (m_fifo.size() > 0) && (m_left == 0 || (hs && m_left == 1));
      if (hs) m_left--;
      if (popped) begin
        void'(m_fifo.pop_front());
        m_left = BEATS;
      end
      if (vld) begin
        if (m_fifo.size() < DEPTH) begin
          m_fifo.push_back(data);
          for (int k = 0; k < BEATS; k++) exp_q.push_back({k == 0, beat_of(data, k)});
        end else begin
          m_ovf = 1'b1;
          if (m_drops < 255) m_drops++;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      check("lane_vld", 64'(lane_vld), 64'(m_left > 0));
      check("dbg_state", 64'(dbg_state), 64'((m_left > 0) ? SER_SEND : SER_IDLE));
      check("fifo_full", 64'(fifo_full), 64'(m_fifo.size() == DEPTH));
      check("overflow", 64'(overflow), 64'(m_ovf));
      check("drop_cnt", 64'(drop_cnt), 64'(m_drops));
      if (lane_vld && rdy && en) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 64'(lane), 64'hDEAD);
        end else begin
          logic [LW:0] e;
          e = exp_q.pop_front();
          check("beat", 64'({sof, lane}), 64'(e));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    vld  = 1'b1;
    data = w;
    step();
    vld  = 1'b0;
  endtask

  task automatic drain(input int budget);
    vld = 1'b0;
    en  = 1'b1;
    rdy = 1'b1;
    for (int i = 0; i < budget && (exp_q.size() != 0 || lane_vld); i++) step();
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_lane_vld", 64'(lane_vld), 64'd0);
    check("rst_lane", 64'(lane), 64'd0);
    check("rst_sof", 64'(sof), 64'd0);
    check("rst_full", 64'(fifo_full), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  function automatic logic [DW-1:0] rand_word();
    return {24'($urandom), 32'($urandom)};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] w5;
    logic [LW-1:0] frz_lane;
    rst_n = 1'b0;
    en    = 1'b1;
    vld   = 1'b0;
    data  = '0;
    rdy   = 1'b1;
    step();
    do_reset();

    // Single word, latency and first beat.
    push_word(56'h0123456789ABCD);
    check("t1_no_early_vld", 64'(lane_vld), 64'd0);
    step();
    check("t1_first_vld", 64'(lane_vld), 64'd1);
    check("t1_first_beat", 64'(lane), 64'h01);
    check("t1_first_sof", 64'(sof), 64'd1);
    drain(20);

    // Two words back to back: 14 beats with no bubble.
    push_word(rand_word());
    push_word(rand_word());
    for (int i = 0; i < 2 * BEATS; i++) begin
      check("t2_contiguous", 64'(lane_vld), 64'd1);
      step();
    end
    check("t2_idle_after", 64'(lane_vld), 64'd0);

    // Stalled consumer: five words fit, the sixth is dropped.
    rdy = 1'b0;
    for (int i = 0; i < 6; i++) push_word(rand_word());
    check("t3_full", 64'(fifo_full), 64'd1);
    check("t3_overflow", 64'(overflow), 64'd1);
    check("t3_drop_cnt", 64'(drop_cnt), 64'd1);
    drain(60);

    // Full FIFO, push coinciding with the last-beat handshake is accepted.
    rdy = 1'b0;
    for (int i = 0; i < 5; i++) push_word(rand_word());
    check("t4_full_before", 64'(fifo_full), 64'd1);
    rdy = 1'b1;
    for (int i = 0; i < BEATS - 1; i++) step();
    push_word(rand_word());
    check("t4_full_after", 64'(fifo_full), 64'd1);
    check("t4_drop_unchanged", 64'(drop_cnt), 64'd1);
    check("t4_new_sof", 64'(sof), 64'd1);
    drain(80);

    // Enable freeze at beat 3.
    w5 = rand_word();
    push_word(w5);
    for (int i = 0; i < 4; i++) step();
    en = 1'b0;
    frz_lane = lane;
    check("t5_at_beat3", 64'(frz_lane), 64'(beat_of(w5, 3)));
    for (int i = 0; i < 3; i++) begin
      vld  = 1'b1;
      data = rand_word();
      step();
      check("t5_frozen_lane", 64'(lane), 64'(beat_of(w5, 3)));
      check("t5_frozen_vld", 64'(lane_vld), 64'd1);
      check("t5_frozen_sof", 64'(sof), 64'd0);
    end
    vld = 1'b0;
    en  = 1'b1;
    drain(20);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      en   = ($urandom_range(0, 9) != 0);
      vld  = ($urandom_range(0, 1) == 1);
      rdy  = ($urandom_range(0, 9) < 7);
      data = rand_word();
      step();
    end
    drain(200);

    // Reset mid-frame with two words queued.
    rdy = 1'b1;
    push_word(rand_word());
    push_word(rand_word());
    push_word(rand_word());
    for (int i = 0; i < 3; i++) step();
    do_reset();
    push_word(56'hFFFFFFFFFFFFFF);
    step();
    check("t6_first_sof", 64'(sof), 64'd1);
    check("t6_first_beat", 64'(lane), 64'hFF);
    check("t6_overflow", 64'(overflow), 64'd0);
    check("t6_drop_cnt", 64'(drop_cnt), 64'd0);
    drain(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
